// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogram sequencer: opcode and state encodings
// plus the bit positions of the fields inside a control word.
package micro_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JUMP = 3'b001,
    OP_BRT  = 3'b010,
    OP_BRF  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HALT = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_ERROR  = 2'b11
  } state_e;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int CTRL_W  = 13;
  localparam int SEL_MSB = 12;
  localparam int SEL_LSB = 11;
  localparam int TGT_LSB = 0;

endpackage

// File: rtl/micro_stack.sv
// Return-address LIFO. The pointer has one spare bit so full and empty stay distinct;
// the entry contents are deliberately left unreset.
module micro_stack
  import micro_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH) + 1;

  logic [PW-1:0] sp_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-2:0] top_idx_s;

  assign top_idx_s = sp_r[PW-2:0] - (PW-1)'(1);
  assign dout      = mem_r[top_idx_s];
  assign full      = (sp_r == PW'(DEPTH));
  assign empty     = (sp_r == '0);

  // Stack pointer: overflowing pushes and underflowing pops are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_r <= '0;
    end else if (push && !full) begin
      sp_r <= sp_r + PW'(1);
    end else if (pop && !empty) begin
      sp_r <= sp_r - PW'(1);
    end else begin
      sp_r <= sp_r;
    end
  end

  // Entry storage written at the current pointer.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_r[sp_r[PW-2:0]] <= din;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: addresses the control ROM, decodes the sequencing field of the
// returned word and forwards the control field of NEXT words to the datapath.
module micro_sequencer
  import micro_sequencer_pkg::*;
#(
  parameter int                ADDR_W      = 8,
  parameter int                WORD_W      = 16,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] START_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic [3:0]        cond,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_word,
  output logic [12:0]       ctrl_out,
  output logic              ctrl_valid,
  output logic              busy,
  output logic              done,
  output logic              stack_err
);

  state_e            state_r, state_next_s;
  logic [ADDR_W-1:0] upc_r, upc_next_s, upc_inc_s, target_s, stack_dout_s;
  op_e               op_s;
  logic [1:0]        sel_s;
  logic              cond_hit_s, push_s, pop_s, full_s, empty_s, executing_s;

  assign op_s        = op_e'(rom_word[OP_MSB:OP_LSB]);
  assign sel_s       = rom_word[SEL_MSB:SEL_LSB];
  assign target_s    = rom_word[TGT_LSB +: ADDR_W];
  assign cond_hit_s  = cond[sel_s];
  assign upc_inc_s   = upc_r + ADDR_W'(1);
  assign executing_s = (state_r == ST_RUN) && !stall;

  micro_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .din   (upc_inc_s),
    .dout  (stack_dout_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state and next-address selection; stack faults freeze upc and the stack.
  always_comb begin
    state_next_s = state_r;
    upc_next_s   = upc_r;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        upc_next_s = START_ADDR;
        if (start) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (executing_s) begin
          case (op_s)
            OP_NEXT, OP_RSVD: upc_next_s = upc_inc_s;
            OP_JUMP:          upc_next_s = target_s;
            OP_BRT:           upc_next_s = cond_hit_s ? target_s : upc_inc_s;
            OP_BRF:           upc_next_s = cond_hit_s ? upc_inc_s : target_s;
            OP_CALL: begin
              if (full_s) begin
                state_next_s = ST_ERROR;
              end else begin
                push_s     = 1'b1;
                upc_next_s = target_s;
              end
            end
            OP_RET: begin
              if (empty_s) begin
                state_next_s = ST_ERROR;
              end else begin
                pop_s      = 1'b1;
                upc_next_s = stack_dout_s;
              end
            end
            OP_HALT:          state_next_s = ST_HALTED;
            default:          upc_next_s = upc_inc_s;
          endcase
        end else begin
          state_next_s = state_r;
        end
      end
      ST_HALTED: begin
        state_next_s = ST_IDLE;
        upc_next_s   = START_ADDR;
      end
      ST_ERROR: state_next_s = ST_ERROR;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State and micro-program counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      upc_r   <= START_ADDR;
    end else begin
      state_r <= state_next_s;
      upc_r   <= upc_next_s;
    end
  end

  // Control field is forwarded only for an unstalled NEXT in RUN.
  always_comb begin
    ctrl_out   = 13'h0000;
    ctrl_valid = 1'b0;
    if (executing_s && (op_s == OP_NEXT)) begin
      ctrl_out   = rom_word[CTRL_W-1:0];
      ctrl_valid = 1'b1;
    end else begin
      ctrl_out   = 13'h0000;
      ctrl_valid = 1'b0;
    end
  end

  assign rom_addr  = upc_r;
  assign busy      = (state_r == ST_RUN);
  assign done      = (state_r == ST_HALTED);
  assign stack_err = (state_r == ST_ERROR);

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus a randomized run
// compared against a cycle-level behavioural model kept in the bench.
module tb_micro_sequencer;

  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_ERR = 3;

  logic        clk = 1'b0;
  logic        rst_n, start, stall;
  logic [3:0]  cond;
  logic [7:0]  rom_addr;
  logic [15:0] rom_word;
  logic [12:0] ctrl_out;
  logic        ctrl_valid, busy, done, stack_err;
  logic [15:0] rom [256];

  int checks = 0;
  int failures = 0;
  int mstate, mupc;
  int mstk[$];
  logic [7:0]  exp_addr;
  logic [12:0] exp_ctrl;
  logic        exp_busy, exp_done, exp_err, exp_valid;

  always #5 clk = ~clk;

  assign rom_word = rom[rom_addr];

  micro_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .cond(cond),
    .rom_addr(rom_addr), .rom_word(rom_word), .ctrl_out(ctrl_out),
    .ctrl_valid(ctrl_valid), .busy(busy), .done(done), .stack_err(stack_err)
  );

  task automatic model_reset();
    mstate = M_IDLE;
    mupc   = 0;
    mstk.delete();
  endtask

  // One clock of the reference model, from the word-format rules.
  task automatic model_step();
    logic [15:0] w;
    int op, sel, tgt, nxt;
    w   = rom[mupc];
    op  = int'(w[15:13]);
    sel = int'(w[12:11]);
    tgt = int'(w[7:0]);
    nxt = (mupc + 1) % 256;
    case (mstate)
      M_IDLE: begin
        mupc = 0;
        if (start) mstate = M_RUN;
      end
      M_RUN: if (!stall) begin
        case (op)
          1: mupc = tgt;
          2: mupc = cond[sel] ? tgt : nxt;
          3: mupc = cond[sel] ? nxt : tgt;
          4: if (mstk.size() == 4) mstate = M_ERR;
             else begin mstk.push_back(nxt); mupc = tgt; end
          5: if (mstk.size() == 0) mstate = M_ERR;
             else mupc = mstk.pop_back();
          6: mstate = M_HALT;
          default: mupc = nxt;
        endcase
      end
      M_HALT: begin mstate = M_IDLE; mupc = 0; end
      default: ;
    endcase
  endtask

  task automatic predict();
    logic [15:0] w;
    w         = rom[mupc];
    exp_addr  = mupc[7:0];
    exp_busy  = (mstate == M_RUN);
    exp_done  = (mstate == M_HALT);
    exp_err   = (mstate == M_ERR);
    exp_valid = (mstate == M_RUN) && !stall && (w[15:13] == 3'b000);
    exp_ctrl  = exp_valid ? w[12:0] : 13'h0000;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 16'hC000;
  endtask

  task automatic test_reset();
    start = 1'b0; stall = 1'b0; cond = 4'h0; rst_n = 1'b0;
    clear_rom();
    model_reset();
    @(posedge clk); #1;
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL por_addr got=%h exp=00", rom_addr); end
    checks++; if ({busy, done, stack_err, ctrl_valid} !== 4'b0000) begin failures++; $display("FAIL por_flags got=%b exp=0000", {busy, done, stack_err, ctrl_valid}); end
    rst_n = 1'b1;
    rom[8'h00] = 16'h8020; rom[8'h20] = 16'h8024; rom[8'h24] = 16'h0000; rom[8'h25] = 16'h0111;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); #1;
    checks++; if (rom_addr !== 8'h25 || busy !== 1'b1) begin failures++; $display("FAIL midrun_addr got=%h/%b exp=25/1", rom_addr, busy); end
    rst_n = 1'b0; model_reset(); #1;
    checks++; if (rom_addr !== 8'h00) begin failures++; $display("FAIL rst_addr got=%h exp=00", rom_addr); end
    checks++; if ({busy, done, stack_err, ctrl_valid} !== 4'b0000 || ctrl_out !== 13'h0) begin failures++; $display("FAIL rst_outs got=%b ctrl=%h exp=0000 ctrl=0", {busy, done, stack_err, ctrl_valid}, ctrl_out); end
    @(posedge clk); #1; rst_n = 1'b1;
    rom[8'h00] = 16'hA000;
    start = 1'b1; tick(); start = 1'b0; #1;
    checks++; if (busy !== 1'b1 || rom_addr !== 8'h00) begin failures++; $display("FAIL ret_first_run got=%b/%h exp=1/00", busy, rom_addr); end
    tick(); #1;
    checks++; if (stack_err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ret_underflow got err=%b busy=%b exp err=1 busy=0", stack_err, busy); end
    apply_reset();
  endtask

  task automatic test_straight();
    clear_rom();
    rom[0] = 16'h0001; rom[1] = 16'h0ABC; rom[2] = 16'hC000;
    start = 1'b1; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL start_latency got=%b exp=0", busy); end
    tick(); start = 1'b0; #1;
    checks++; if (ctrl_out !== 13'h0001 || ctrl_valid !== 1'b1) begin failures++; $display("FAIL ctrl_first got=%h/%b exp=0001/1", ctrl_out, ctrl_valid); end
    tick(); #1;
    checks++; if (ctrl_out !== 13'h0ABC || ctrl_valid !== 1'b1) begin failures++; $display("FAIL ctrl_second got=%h/%b exp=0abc/1", ctrl_out, ctrl_valid); end
    tick(); #1;
    checks++; if (rom_addr !== 8'h02 || ctrl_valid !== 1'b0 || ctrl_out !== 13'h0) begin failures++; $display("FAIL halt_gate got=%h/%b/%h exp=02/0/0", rom_addr, ctrl_valid, ctrl_out); end
    tick(); #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'h02) begin failures++; $display("FAIL halted got done=%b busy=%b addr=%h exp 1/0/02", done, busy, rom_addr); end
    tick(); #1;
    checks++; if (done !== 1'b0 || rom_addr !== 8'h00) begin failures++; $display("FAIL back_idle got done=%b addr=%h exp 0/00", done, rom_addr); end
  endtask

  task automatic test_branch();
    logic        brf, bit_set;
    logic [7:0]  exp;
    for (int i = 0; i < 4; i++) begin
      brf = (i >= 2); bit_set = (i % 2 == 1);
      clear_rom();
      rom[0] = brf ? 16'h7040 : 16'h5040;
      exp = (brf ^ bit_set) ? 8'h40 : 8'h01;
      start = 1'b1; tick(); start = 1'b0;
      cond = (4'($urandom) & 4'b1011) | (bit_set ? 4'b0100 : 4'b0000);
      tick();
      cond = 4'($urandom); #1;
      checks++; if (rom_addr !== exp || busy !== 1'b1) begin failures++; $display("FAIL branch_%0d got=%h/%b exp=%h/1", i, rom_addr, busy, exp); end
      tick(); tick();
    end
  endtask

  task automatic test_call();
    logic [7:0] seq [3];
    seq[0] = 8'h10; seq[1] = 8'h80; seq[2] = 8'h11;
    clear_rom();
    rom[8'h00] = 16'h2010; rom[8'h10] = 16'h8080; rom[8'h80] = 16'hA000;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      checks++; if (rom_addr !== seq[k] || busy !== 1'b1) begin failures++; $display("FAIL call_seq%0d got=%h exp=%h", k, rom_addr, seq[k]); end
    end
    tick(); tick();
    clear_rom();
    for (int a = 0; a < 5; a++) rom[a] = 16'h8000 | 16'(a + 1);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick(); #1;
    checks++; if (rom_addr !== 8'h04 || busy !== 1'b1) begin failures++; $display("FAIL nest4 got=%h/%b exp=04/1", rom_addr, busy); end
    tick(); #1;
    checks++; if (stack_err !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'h04) begin failures++; $display("FAIL overflow got err=%b busy=%b addr=%h exp 1/0/04", stack_err, busy, rom_addr); end
    start = 1'b1; tick(); tick(); tick(); start = 1'b0; #1;
    checks++; if (stack_err !== 1'b1 || busy !== 1'b0 || rom_addr !== 8'h04) begin failures++; $display("FAIL err_sticky got err=%b busy=%b addr=%h exp 1/0/04", stack_err, busy, rom_addr); end
    apply_reset(); #1;
    checks++; if (stack_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", stack_err); end
  endtask

  task automatic test_stall();
    clear_rom();
    rom[8'h00] = 16'h2005; rom[8'h05] = 16'h0123;
    start = 1'b1; tick(); start = 1'b0; tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (rom_addr !== 8'h05 || ctrl_valid !== 1'b0 || ctrl_out !== 13'h0) begin failures++; $display("FAIL stall%0d got=%h/%b/%h exp=05/0/0", k, rom_addr, ctrl_valid, ctrl_out); end
      tick();
    end
    stall = 1'b0; #1;
    checks++; if (ctrl_valid !== 1'b1 || ctrl_out !== 13'h0123) begin failures++; $display("FAIL stall_release got=%b/%h exp=1/0123", ctrl_valid, ctrl_out); end
    tick(); #1;
    checks++; if (rom_addr !== 8'h06) begin failures++; $display("FAIL stall_advance got=%h exp=06", rom_addr); end
    tick(); tick();
  endtask

  task automatic test_wrap();
    clear_rom();
    rom[8'h00] = 16'h20FF; rom[8'hFF] = 16'h0007;
    start = 1'b1; tick(); start = 1'b0; tick(); #1;
    checks++; if (rom_addr !== 8'hFF || ctrl_out !== 13'h0007) begin failures++; $display("FAIL wrap_at_ff got=%h/%h exp=ff/0007", rom_addr, ctrl_out); end
    tick(); #1;
    checks++; if (rom_addr !== 8'h00 || stack_err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wrap got addr=%h err=%b busy=%b exp 00/0/1", rom_addr, stack_err, busy); end
    apply_reset();
  endtask

  task automatic test_random();
    int r;
    logic [2:0] op;
    for (int a = 0; a < 256; a++) begin
      r = $urandom_range(0, 15);
      op = (r <= 5 || r == 15) ? 3'd0 : (r == 6) ? 3'd1 : (r <= 8) ? 3'd2 :
           (r <= 10) ? 3'd3 : (r == 11) ? 3'd4 : (r == 12) ? 3'd5 : (r == 13) ? 3'd6 : 3'd7;
      rom[a] = {op, 13'($urandom)};
    end
    apply_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0 || (mstate == M_ERR && $urandom_range(0, 7) == 0)) begin
        rst_n = 1'b0; model_reset(); #1;
        checks++; if (rom_addr !== 8'h00 || busy !== 1'b0 || ctrl_valid !== 1'b0) begin failures++; $display("FAIL rnd_rst c=%0d got=%h/%b/%b", c, rom_addr, busy, ctrl_valid); end
        rst_n = 1'b1;
      end
      start = ($urandom_range(0, 3) == 0);
      stall = ($urandom_range(0, 3) == 0);
      cond  = 4'($urandom);
      #1;
      predict();
      checks++; if (rom_addr !== exp_addr) begin failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, rom_addr, exp_addr); end
      checks++; if (busy !== exp_busy) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, exp_busy); end
      checks++; if (done !== exp_done) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, done, exp_done); end
      checks++; if (stack_err !== exp_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, stack_err, exp_err); end
      checks++; if (ctrl_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, ctrl_valid, exp_valid); end
      checks++; if (ctrl_out !== exp_ctrl) begin failures++; $display("FAIL rnd_ctrl c=%0d got=%h exp=%h", c, ctrl_out, exp_ctrl); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_call();
    test_stall();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
